rf_spill_fill_ctrl: RTL and testbench
=====================================

Name: rf_spill_fill_ctrl

Overview:
Spill/fill engine that sits directly behind the windowed register file's memory-side bus.
- On window overflow (SUBCALL with no free window), it captures the 2*N IN+LOCAL words the register file drives on BUSOUT into an on-chip LIFO.
- On window underflow (SUBRETURN to a spilled window), it returns those words in reverse order on the register file's BUSIN.
- It tracks stack occupancy and flags protocol errors.

Parameters:
- NBIT, 64, data word width (matches register file NBIT).
- N, 4, registers per window block; each spill/fill moves 2*N words.
- DEPTH_WIN, 8, number of windows the stack can hold.
- WORDS, 2*N*DEPTH_WIN, derived total stack words; not overridable.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- SPILL_REQ  in  1  single-cycle spill request from the register file.
- FILL_REQ  in  1  single-cycle fill request from the register file.
- BUSOUT_RF  in  NBIT  spill data from the register file's BUSOUT.
- BUS_TAKE  out  1  spill beat strobe; the register file advances its spill index each cycle it is high.
- BUSIN_RF  out  NBIT  fill data to the register file's BUSIN (registered).
- BUS_VALID  out  1  fill beat valid (registered).
- BUSY  out  1  state != IDLE.
- WIN_CNT  out  clog2(DEPTH_WIN+1)  windows currently stored.
- FULL  out  1  WIN_CNT == DEPTH_WIN.
- EMPTY  out  1  WIN_CNT == 0.
- OVERFLOW  out  1  sticky: spill requested while FULL.
- UNDERFLOW  out  1  sticky: fill requested while EMPTY.
- PROTO_ERR  out  1  sticky: request while BUSY, or SPILL_REQ and FILL_REQ high together.

Behaviour:
- Reset (RESET=0 at an edge):
  - state=IDLE, SP=0, beat counter=0.
  - BUS_TAKE=0, BUS_VALID=0, BUSIN_RF=0, WIN_CNT=0.
  - All error flags cleared; EMPTY=1, FULL=0.
  - Stack RAM contents are not reset.
  - Reset mid-spill or mid-fill aborts immediately and returns to IDLE. Partial data is discarded; SP returns to 0.
- FSM states: IDLE, SPILL, FILL.
- IDLE:
  - SPILL_REQ alone, not FULL -> SPILL, beat=0.
  - FILL_REQ alone, not EMPTY -> FILL, beat=0; the first read is issued this cycle at address SP-1.
  - SPILL_REQ while FULL -> OVERFLOW<=1, stay IDLE, no state change.
  - FILL_REQ while EMPTY -> UNDERFLOW<=1, stay IDLE.
  - Both requests high together -> PROTO_ERR<=1, both ignored.
- SPILL:
  - BUS_TAKE=1 (combinational from state).
  - At each edge: mem[SP]<=BUSOUT_RF, SP<=SP+1, beat<=beat+1.
  - When beat==2N-1 -> IDLE and WIN_CNT+1.
  - Request at cycle t: beats occupy cycles t+1..t+2N. Word j is the register file's spill index j.
- FILL:
  - Each edge: BUSIN_RF<=mem[SP-1], BUS_VALID<=1, SP<=SP-1.
  - Request at cycle t: BUS_VALID=1 for cycles t+1..t+2N. Word j carries mem[SP0-1-j], i.e. highest spill index first.
  - After the 2N-th read -> IDLE, WIN_CNT-1. BUS_VALID drops to 0 in cycle t+2N+1.
  - BUSIN_RF holds its last value when not valid.
- Any SPILL_REQ/FILL_REQ while BUSY: PROTO_ERR<=1, request ignored, transfer in progress unaffected.
- Back-to-back: a request in the first IDLE cycle after a transfer is accepted normally.
- Widths:
  - SP is clog2(WORDS+1) bits; it never wraps because FULL/EMPTY gating prevents it.
  - Beat counter is clog2(2N) bits.
- Error flags clear only on reset.

Decomposition:
- Package rf_spill_pkg: state enum typedef (IDLE/SPILL/FILL), localparam function computing WORDS and the SP/beat widths from N and DEPTH_WIN.
- Sub-module rf_spill_stack_mem: single-port synchronous RAM, WORDS x NBIT, with write enable and registered read data feeding BUSIN_RF. The controller holds the FSM, SP, counters and flags.

Test Plan (N=4, DEPTH_WIN=2):
- Spill then fill: SPILL_REQ at t with BUSOUT_RF=0xA0..0xA7 over t+1..t+8 -> BUS_TAKE high exactly t+1..t+8, WIN_CNT=1. FILL_REQ -> BUSIN_RF=0xA7,0xA6,...,0xA0 on 8 consecutive BUS_VALID cycles, then WIN_CNT=0, EMPTY=1.
- Nesting: spill 0xA0..A7, spill 0xB0..B7 -> FULL=1. Fill -> 0xB7..B0. Fill -> 0xA7..A0.
- Overflow: third SPILL_REQ while FULL -> OVERFLOW=1, BUS_TAKE stays 0, WIN_CNT stays 2, stored data intact on later fills.
- Underflow / simultaneous requests: FILL_REQ after reset -> UNDERFLOW=1, BUS_VALID stays 0. SPILL_REQ and FILL_REQ same cycle -> PROTO_ERR=1, BUSY stays 0.
- Request while busy: FILL_REQ during beat 3 of a spill -> PROTO_ERR=1, spill still completes 8 beats, WIN_CNT=1.
- Reset mid-fill: RESET=0 during beat 4 -> next cycle BUSY=0, BUS_VALID=0, BUSIN_RF=0, WIN_CNT=0, EMPTY=1, all flags 0.

Source files
------------

// File: rtl/rf_spill_pkg.sv
// Shared types and sizing helpers for the register-file spill/fill engine.
// Sizing is derived from window geometry so the stack cannot be mis-dimensioned.
package rf_spill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SPILL = 2'd1,
      ST_FILL  = 2'd2
   } spill_state_e;

   function automatic int stack_words(input int n, input int depth_win);
      return 2 * n * depth_win;
   endfunction

   // Pointer must reach WORDS itself (full stack), hence the +1.
   function automatic int sp_width(input int n, input int depth_win);
      return $clog2(stack_words(n, depth_win) + 1);
   endfunction

   function automatic int addr_width(input int n, input int depth_win);
      return (stack_words(n, depth_win) > 1) ? $clog2(stack_words(n, depth_win)) : 1;
   endfunction

   function automatic int beat_width(input int n);
      return (2 * n > 1) ? $clog2(2 * n) : 1;
   endfunction

   function automatic int win_width(input int depth_win);
      return $clog2(depth_win + 1);
   endfunction

endpackage

// File: rtl/rf_spill_stack_mem.sv
// Single-port WORDS x NBIT stack RAM with registered read data (1-cycle read latency).
// No backpressure: caller never writes and reads in the same cycle; read data holds when idle.
module rf_spill_stack_mem #(
   parameter int NBIT  = 64,
   parameter int WORDS = 64,
   parameter int AW    = 6
) (
   input  logic            core_clk,
   input  logic            rst_n,
   input  logic            wr_vld,
   input  logic            rd_vld,
   input  logic [AW-1:0]   addr,
   input  logic [NBIT-1:0] wr_dat,
   output logic [NBIT-1:0] rd_dat
);

   logic [NBIT-1:0] mem_q [WORDS];
   logic [NBIT-1:0] rd_dat_q;
   logic [NBIT-1:0] rd_dat_d;

   always_comb begin
      rd_dat_d = rd_dat_q;
      if (rd_vld) rd_dat_d = mem_q[addr];
   end

   // Array contents are deliberately left out of reset.
   always_ff @(posedge core_clk) begin
      if (wr_vld) mem_q[addr] <= wr_dat;
   end

   always_ff @(posedge core_clk) begin
      if (!rst_n) rd_dat_q <= '0;
      else        rd_dat_q <= rd_dat_d;
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/rf_spill_fill_ctrl.sv
// Spill/fill LIFO engine behind the windowed register file: spill takes 2N beats on BUS_TAKE,
// fill returns 2N words highest-index first one cycle after request; requests while busy are flagged and dropped.
module rf_spill_fill_ctrl
   import rf_spill_pkg::*;
#(
   parameter int NBIT      = 64,
   parameter int N         = 4,
   parameter int DEPTH_WIN = 8
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic                             SPILL_REQ,
   input  logic                             FILL_REQ,
   input  logic [NBIT-1:0]                  BUSOUT_RF,
   output logic                             BUS_TAKE,
   output logic [NBIT-1:0]                  BUSIN_RF,
   output logic                             BUS_VALID,
   output logic                             BUSY,
   output logic [win_width(DEPTH_WIN)-1:0]  WIN_CNT,
   output logic                             FULL,
   output logic                             EMPTY,
   output logic                             OVERFLOW,
   output logic                             UNDERFLOW,
   output logic                             PROTO_ERR
);

   localparam int WORDS = stack_words(N, DEPTH_WIN);
   localparam int SPW   = sp_width(N, DEPTH_WIN);
   localparam int AW    = addr_width(N, DEPTH_WIN);
   localparam int BW    = beat_width(N);
   localparam int WCW   = win_width(DEPTH_WIN);

   spill_state_e   state_q,     state_d;
   logic [SPW-1:0] sp_q,        sp_d;
   logic [BW-1:0]  beat_q,      beat_d;
   logic [WCW-1:0] win_cnt_q,   win_cnt_d;
   logic           bus_valid_q, bus_valid_d;
   logic           overflow_q,  overflow_d;
   logic           underflow_q, underflow_d;
   logic           proto_err_q, proto_err_d;

   logic           mem_wr_vld;
   logic           mem_rd_vld;
   logic [AW-1:0]  mem_addr;
   logic           full;
   logic           empty;

   assign full  = (win_cnt_q == WCW'(DEPTH_WIN));
   assign empty = (win_cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      beat_d      = beat_q;
      win_cnt_d   = win_cnt_q;
      bus_valid_d = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      proto_err_d = proto_err_q;
      mem_wr_vld  = 1'b0;
      mem_rd_vld  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (SPILL_REQ && FILL_REQ) begin
               proto_err_d = 1'b1;
            end else if (SPILL_REQ) begin
               if (full) begin
                  overflow_d = 1'b1;
               end else begin
                  state_d = ST_SPILL;
                  beat_d  = '0;
               end
            end else if (FILL_REQ) begin
               if (empty) begin
                  underflow_d = 1'b1;
               end else begin
                  // First read goes out in the request cycle so data lands one cycle later.
                  state_d     = ST_FILL;
                  beat_d      = '0;
                  mem_rd_vld  = 1'b1;
                  bus_valid_d = 1'b1;
                  sp_d        = sp_q - SPW'(1);
               end
            end
         end

         ST_SPILL: begin
            if (SPILL_REQ || FILL_REQ) proto_err_d = 1'b1;
            mem_wr_vld = 1'b1;
            sp_d       = sp_q + SPW'(1);
            if (beat_q == BW'(2 * N - 1)) begin
               state_d   = ST_IDLE;
               beat_d    = '0;
               win_cnt_d = win_cnt_q + WCW'(1);
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end

         ST_FILL: begin
            if (SPILL_REQ || FILL_REQ) proto_err_d = 1'b1;
            mem_rd_vld  = 1'b1;
            bus_valid_d = 1'b1;
            sp_d        = sp_q - SPW'(1);
            // One read was already issued on entry, so 2N-1 more remain here.
            if (beat_q == BW'(2 * N - 2)) begin
               state_d   = ST_IDLE;
               beat_d    = '0;
               win_cnt_d = win_cnt_q - WCW'(1);
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_addr = (state_q == ST_SPILL) ? sp_q[AW-1:0] : (sp_q[AW-1:0] - AW'(1));

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         sp_q        <= '0;
         beat_q      <= '0;
         win_cnt_q   <= '0;
         bus_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         beat_q      <= beat_d;
         win_cnt_q   <= win_cnt_d;
         bus_valid_q <= bus_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         proto_err_q <= proto_err_d;
      end
   end

   rf_spill_stack_mem #(
      .NBIT  (NBIT),
      .WORDS (WORDS),
      .AW    (AW)
   ) u_stack_mem (
      .core_clk (CLK),
      .rst_n    (RESET),
      .wr_vld   (mem_wr_vld),
      .rd_vld   (mem_rd_vld),
      .addr     (mem_addr),
      .wr_dat   (BUSOUT_RF),
      .rd_dat   (BUSIN_RF)
   );

   assign BUS_TAKE  = (state_q == ST_SPILL);
   assign BUSY      = (state_q != ST_IDLE);
   assign BUS_VALID = bus_valid_q;
   assign WIN_CNT   = win_cnt_q;
   assign FULL      = full;
   assign EMPTY     = empty;
   assign OVERFLOW  = overflow_q;
   assign UNDERFLOW = underflow_q;
   assign PROTO_ERR = proto_err_q;

endmodule

// File: tb/tb_rf_spill_fill_ctrl.sv
// Directed bench for rf_spill_fill_ctrl with N=4, DEPTH_WIN=2.
module tb_rf_spill_fill_ctrl;

   localparam int NBIT = 64;
   localparam int N    = 4;
   localparam int DW   = 2;

   logic            CLK;
   logic            RESET;
   logic            SPILL_REQ;
   logic            FILL_REQ;
   logic [NBIT-1:0] BUSOUT_RF;
   logic            BUS_TAKE;
   logic [NBIT-1:0] BUSIN_RF;
   logic            BUS_VALID;
   logic            BUSY;
   logic [1:0]      WIN_CNT;
   logic            FULL;
   logic            EMPTY;
   logic            OVERFLOW;
   logic            UNDERFLOW;
   logic            PROTO_ERR;

   int checks   = 0;
   int failures = 0;

   rf_spill_fill_ctrl #(.NBIT(NBIT), .N(N), .DEPTH_WIN(DW)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .SPILL_REQ (SPILL_REQ),
      .FILL_REQ  (FILL_REQ),
      .BUSOUT_RF (BUSOUT_RF),
      .BUS_TAKE  (BUS_TAKE),
      .BUSIN_RF  (BUSIN_RF),
      .BUS_VALID (BUS_VALID),
      .BUSY      (BUSY),
      .WIN_CNT   (WIN_CNT),
      .FULL      (FULL),
      .EMPTY     (EMPTY),
      .OVERFLOW  (OVERFLOW),
      .UNDERFLOW (UNDERFLOW),
      .PROTO_ERR (PROTO_ERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Quiet-state snapshot: {BUSY, BUS_TAKE, BUS_VALID, WIN_CNT, FULL, EMPTY, OVF, UNF, PERR}
   task automatic check_status(input string name, input logic [9:0] exp);
      logic [9:0] got;
      got = {BUSY, BUS_TAKE, BUS_VALID, WIN_CNT, FULL, EMPTY, OVERFLOW, UNDERFLOW, PROTO_ERR};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: status got %b expected %b (busy,take,valid,wcnt[2],full,empty,ovf,unf,perr)",
                  name, got, exp);
      end
   endtask

   task automatic do_spill(input logic [NBIT-1:0] base, input int busy_fill_beat);
      SPILL_REQ = 1'b1;
      checks++;
      if (BUS_TAKE !== 1'b0) begin
         failures++;
         $display("FAIL spill_req_cycle_take: got %b expected 0", BUS_TAKE);
      end
      step();
      SPILL_REQ = 1'b0;
      for (int j = 0; j < 2 * N; j++) begin
         checks++;
         if (BUS_TAKE !== 1'b1 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL spill_beat%0d_take: take=%b busy=%b expected 1 1", j, BUS_TAKE, BUSY);
         end
         BUSOUT_RF = base + NBIT'(j);
         FILL_REQ  = (j == busy_fill_beat);
         step();
         FILL_REQ  = 1'b0;
      end
      BUSOUT_RF = '1;
      checks++;
      if (BUS_TAKE !== 1'b0 || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL spill_end_take: take=%b busy=%b expected 0 0", BUS_TAKE, BUSY);
      end
   endtask

   task automatic do_fill(input logic [NBIT-1:0] base);
      FILL_REQ = 1'b1;
      step();
      FILL_REQ = 1'b0;
      for (int j = 0; j < 2 * N; j++) begin
         checks++;
         if (BUS_VALID !== 1'b1 || BUSIN_RF !== base + NBIT'(2 * N - 1 - j)) begin
            failures++;
            $display("FAIL fill_beat%0d: valid=%b data=%h expected 1 %h",
                     j, BUS_VALID, BUSIN_RF, base + NBIT'(2 * N - 1 - j));
         end
         step();
      end
      checks++;
      if (BUS_VALID !== 1'b0 || BUSY !== 1'b0 || BUSIN_RF !== base) begin
         failures++;
         $display("FAIL fill_end: valid=%b busy=%b data=%h expected 0 0 %h",
                  BUS_VALID, BUSY, BUSIN_RF, base);
      end
   endtask

   task automatic apply_reset();
      RESET = 1'b0;
      step();
      step();
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      check_status("reset_status", 10'b000_00_0_1_000);
      checks++;
      if (BUSIN_RF !== '0) begin
         failures++;
         $display("FAIL reset_busin: got %h expected 0", BUSIN_RF);
      end
   endtask

   task automatic test_spill_fill();
      do_spill(64'hA0, -1);
      check_status("sf_after_spill", 10'b000_01_0_0_000);
      do_fill(64'hA0);
      check_status("sf_after_fill", 10'b000_00_0_1_000);
   endtask

   task automatic test_back_to_back();
      do_spill(64'hA0, -1);
      do_spill(64'hB0, -1);
      check_status("nest_full", 10'b000_10_1_0_000);
   endtask

   task automatic test_overflow();
      SPILL_REQ = 1'b1;
      step();
      SPILL_REQ = 1'b0;
      check_status("ovf_flag", 10'b000_10_1_0_100);
      step();
      check_status("ovf_hold", 10'b000_10_1_0_100);
      do_fill(64'hB0);
      check_status("ovf_after_fill1", 10'b000_01_0_0_100);
      do_fill(64'hA0);
      check_status("ovf_after_fill2", 10'b000_00_0_1_100);
   endtask

   task automatic test_underflow_and_both();
      apply_reset();
      FILL_REQ = 1'b1;
      step();
      FILL_REQ = 1'b0;
      check_status("unf_flag", 10'b000_00_0_1_010);
      step();
      check_status("unf_hold", 10'b000_00_0_1_010);
      SPILL_REQ = 1'b1;
      FILL_REQ  = 1'b1;
      step();
      SPILL_REQ = 1'b0;
      FILL_REQ  = 1'b0;
      check_status("both_req", 10'b000_00_0_1_011);
   endtask

   task automatic test_req_while_busy();
      apply_reset();
      do_spill(64'hC0, 3);
      check_status("busy_req_spill", 10'b000_01_0_0_001);
      do_fill(64'hC0);
      check_status("busy_req_fill", 10'b000_00_0_1_001);
   endtask

   task automatic test_reset_mid_fill();
      do_spill(64'hD0, -1);
      FILL_REQ = 1'b1;
      step();
      FILL_REQ = 1'b0;
      for (int j = 0; j < 4; j++) step();
      checks++;
      if (BUS_VALID !== 1'b1 || BUSIN_RF !== 64'hD3) begin
         failures++;
         $display("FAIL midfill_beat4: valid=%b data=%h expected 1 d3", BUS_VALID, BUSIN_RF);
      end
      RESET = 1'b0;
      step();
      RESET = 1'b1;
      check_status("midfill_reset", 10'b000_00_0_1_000);
      checks++;
      if (BUSIN_RF !== '0) begin
         failures++;
         $display("FAIL midfill_busin: got %h expected 0", BUSIN_RF);
      end
      do_spill(64'hE0, -1);
      do_fill(64'hE0);
      check_status("midfill_recover", 10'b000_00_0_1_000);
   endtask

   initial begin
      RESET     = 1'b0;
      SPILL_REQ = 1'b0;
      FILL_REQ  = 1'b0;
      BUSOUT_RF = '0;
      test_reset();
      test_spill_fill();
      test_back_to_back();
      test_overflow();
      test_underflow_and_both();
      test_req_while_busy();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
